maxpool_2x2_fifo_ctrl: RTL
==========================

Name: maxpool_2x2_fifo_ctrl

Overview:
- Drives and consumes the per-lane maxpool row FIFO array, and computes a 2x2 stride-2 max pool over NUM_LANE parallel pixel streams.
- Even rows: each horizontal pair max is pushed into the FIFO array.
- Odd rows: each horizontal pair max is compared with the FIFO read-back, giving the pooled output.
- Sits between the conv/activation output stage and the output buffer, and owns every FIFO control line (rd_en, wr_en, rd_clr, wr_clr).

Parameters:
- DATA_WIDTH, 16, width of one pixel, signed two's complement
- NUM_LANE, 16, number of parallel lanes; equals the FIFO array's NUM_FIFO
- ROW_LEN, 16, pixels per row per lane; even and >= 2; ROW_LEN/2 must be <= FIFO depth
- NUM_ROWS, 16, rows per frame; even and >= 2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data carries one pixel column for all lanes; no backpressure
- in_data  in  DATA_WIDTH*NUM_LANE  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- fifo_wr_en  out  1  FIFO array write enable
- fifo_wr_data  out  DATA_WIDTH*NUM_LANE  even-row pair maxima
- fifo_rd_en  out  1  FIFO array read enable
- fifo_rd_data  in  DATA_WIDTH*NUM_LANE  FIFO output; valid the cycle after fifo_rd_en
- fifo_rd_clr  out  1  FIFO read pointer clear
- fifo_wr_clr  out  1  FIFO write pointer clear
- out_valid  out  1  pooled result valid
- out_data  out  DATA_WIDTH*NUM_LANE  pooled result per lane
- frame_done  out  1  one-cycle pulse, coincident with the last out_valid of a frame

Behaviour:
- All outputs are registered. Counters advance only on in_valid.
- Reset values:
  - fifo_wr_en, fifo_rd_en, out_valid, frame_done = 0
  - data outputs = 0
  - fifo_rd_clr = fifo_wr_clr = 1
  - col = 0, row = 0, state = EVEN_ROW
- The clr outputs drop on the first cycle after rst deasserts.
- State machine:
  - EVEN_ROW -> ODD_ROW when the pixel at col = ROW_LEN-1 is accepted.
  - ODD_ROW -> EVEN_ROW when the pixel at col = ROW_LEN-1 is accepted.
  - row increments on each row end and wraps to 0 after NUM_ROWS-1.
  - col wraps ROW_LEN-1 -> 0.
- Pair handling: at an even col, the pixel is held in hold_q per lane. At an odd col, hmax = signed max(hold_q, in_data) per lane.
- Even row, odd col accepted in cycle T:
  - Cycle T+1: fifo_wr_en = 1, fifo_wr_data = hmax.
- Odd row, odd col accepted in cycle T:
  - T+1: fifo_rd_en = 1, hmax registered.
  - T+2: fifo_rd_data valid, hmax delayed one stage.
  - T+3: out_valid = 1, out_data = signed max(fifo_rd_data, hmax) per lane.
- Fixed latency is 3 cycles. The pipeline never stalls, and output rate is at most one per 2 cycles.
- Equal values: either operand (same value). Most-negative value handled exactly, no saturation.
- Frame end: the last odd-row pair of row NUM_ROWS-1 produces out_valid together with frame_done.
  - In that same cycle fifo_rd_clr = fifo_wr_clr = 1 for exactly one cycle.
  - The FIFO holds no entries at that point; the clear resynchronises pointers.
- Back-to-back frames: in_valid in the frame_done cycle is accepted as row 0, col 0 of the next frame. Its FIFO write occurs no earlier than 2 cycles later, i.e. after the clear.
- Idle gaps: in_valid low mid-pair or mid-row keeps hold_q, col, row and state unchanged. Pipeline stages still drain on schedule.
- Reset mid-operation:
  - In-flight pipeline valids are dropped.
  - No out_valid, fifo_wr_en or fifo_rd_en after the reset edge.
  - Counters restart at row 0, col 0.
  - FIFO pointers are cleared via the clr outputs.
- fifo_wr_en and fifo_rd_en are never high in the same cycle.

Decomposition:
- Shared maxpool package holds:
  - the state enum {EVEN_ROW, ODD_ROW}
  - default DATA_WIDTH / NUM_LANE constants
  - a signed-max function shared with other pooling blocks
- One natural sub-module: maxpool_lane_cmp, a per-lane signed max of two operands, instantiated 2*NUM_LANE times by generate (horizontal and vertical compare).
- Counters, FSM and pipeline valids stay in the top module.

Test Plan:
- ROW_LEN=4, NUM_ROWS=2; lane0 row0 = 1,5,3,2 and row1 = 4,0,7,9, in_valid continuous:
  - fifo_wr_data lane0 = 5, then 3.
  - out_data lane0 = 5, then 9, each 3 cycles after cols 1 and 3 of row1.
  - frame_done with the second output.
- Signed: row0 = -3,-7,-32768,-1 and row1 = -8,-2,-32768,-32768 -> outputs -2, -1.
- in_valid toggling 1-0-1-0 through the Test 1 data -> identical values; each output exactly 3 cycles after its odd-col accept; fifo_wr_en never coincides with fifo_rd_en.
- Two frames back-to-back (NUM_ROWS=4):
  - frame_done and both clr pulses occur in the same single cycle.
  - Second frame results match the reference model.
  - No stale FIFO data.
- rst asserted during row1 after col 1:
  - No out_valid follows.
  - clr outputs high.
  - After release, Test 1 data yields correct outputs from row 0.
- NUM_LANE=2, lane1 = lane0 negated -> each lane matches its own model; no cross-lane mixing.

Source files
------------

// File: rtl/maxpool_2x2_fifo_ctrl_pkg.sv
// Shared maxpool types and helpers.
// Used by the 2x2 pooling controller and its lane comparators.
package maxpool_2x2_fifo_ctrl_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_NUM_LANE   = 16;
   localparam int MAX_DW         = 64;

   typedef enum logic {
      EVEN_ROW = 1'b0,
      ODD_ROW  = 1'b1
   } mp_state_e;

   function automatic logic signed [MAX_DW-1:0] smax(
      input logic signed [MAX_DW-1:0] a,
      input logic signed [MAX_DW-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_2x2_fifo_ctrl_if.sv
// Pixel stream, row FIFO control and pooled output bundle.
// master is the pooling controller, slave its environment.
import maxpool_2x2_fifo_ctrl_pkg::*;

interface maxpool_2x2_fifo_ctrl_if #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_LANE   = DEF_NUM_LANE
);
   localparam int LW = DATA_WIDTH * NUM_LANE;

   logic          in_valid;
   logic [LW-1:0] in_data;
   logic          fifo_wr_en;
   logic [LW-1:0] fifo_wr_data;
   logic          fifo_rd_en;
   logic [LW-1:0] fifo_rd_data;
   logic          fifo_rd_clr;
   logic          fifo_wr_clr;
   logic          out_valid;
   logic [LW-1:0] out_data;
   logic          frame_done;

   modport master (
      input  in_valid, in_data, fifo_rd_data,
      output fifo_wr_en, fifo_wr_data, fifo_rd_en,
      output fifo_rd_clr, fifo_wr_clr,
      output out_valid, out_data, frame_done
   );

   modport slave (
      output in_valid, in_data, fifo_rd_data,
      input  fifo_wr_en, fifo_wr_data, fifo_rd_en,
      input  fifo_rd_clr, fifo_wr_clr,
      input  out_valid, out_data, frame_done
   );

endinterface

// File: rtl/maxpool_2x2_fifo_ctrl_lane_cmp.sv
// Signed max of two pixels for one lane.
import maxpool_2x2_fifo_ctrl_pkg::*;

module maxpool_lane_cmp #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);
   logic signed [MAX_DW-1:0] ax;
   logic signed [MAX_DW-1:0] bx;
   logic                     pick_a;

   assign ax     = {{(MAX_DW-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
   assign bx     = {{(MAX_DW-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
   assign pick_a = (smax(ax, bx) == ax);
   assign y      = pick_a ? a : b;

endmodule

// File: rtl/maxpool_2x2_fifo_ctrl.sv
// 2x2 stride-2 max pool over parallel lanes using an external row FIFO.
// Even rows park pair maxima in the FIFO, odd rows fold them back in.
import maxpool_2x2_fifo_ctrl_pkg::*;

module maxpool_2x2_fifo_ctrl #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_LANE   = DEF_NUM_LANE,
   parameter int ROW_LEN    = 16,
   parameter int NUM_ROWS   = 16
) (
   input logic clk,
   input logic rst,
   maxpool_2x2_fifo_ctrl_if.master bus
);
   localparam int LW = DATA_WIDTH * NUM_LANE;
   localparam int CW = $clog2(ROW_LEN);
   localparam int RW = $clog2(NUM_ROWS);
   localparam logic [CW-1:0] COL_LAST = CW'(ROW_LEN - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

   mp_state_e     state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [LW-1:0] hold_q;
   logic [LW-1:0] hmax;
   logic [LW-1:0] hmax_q;
   logic [LW-1:0] hmax_d;
   logic [LW-1:0] vmax;
   logic          pair;
   logic          col_last;
   logic          row_last;
   logic          last_v1;
   logic          rd_v2;
   logic          last_v2;

   assign pair     = bus.in_valid & col[0];
   assign col_last = (col == COL_LAST);
   assign row_last = (row == ROW_LAST);

   for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
      maxpool_lane_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_h (
         .a (hold_q[i*DATA_WIDTH +: DATA_WIDTH]),
         .b (bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .y (hmax[i*DATA_WIDTH +: DATA_WIDTH])
      );
      maxpool_lane_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_v (
         .a (bus.fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .b (hmax_d[i*DATA_WIDTH +: DATA_WIDTH]),
         .y (vmax[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= EVEN_ROW;
         col              <= '0;
         row              <= '0;
         hold_q           <= '0;
         hmax_q           <= '0;
         hmax_d           <= '0;
         last_v1          <= 1'b0;
         rd_v2            <= 1'b0;
         last_v2          <= 1'b0;
         bus.fifo_wr_en   <= 1'b0;
         bus.fifo_wr_data <= '0;
         bus.fifo_rd_en   <= 1'b0;
         bus.fifo_rd_clr  <= 1'b1;
         bus.fifo_wr_clr  <= 1'b1;
         bus.out_valid    <= 1'b0;
         bus.out_data     <= '0;
         bus.frame_done   <= 1'b0;
      end else begin
         bus.fifo_wr_en  <= pair && (state == EVEN_ROW);
         bus.fifo_rd_en  <= pair && (state == ODD_ROW);
         last_v1         <= pair && (state == ODD_ROW) && col_last && row_last;
         rd_v2           <= bus.fifo_rd_en;
         last_v2         <= last_v1;
         hmax_d          <= hmax_q;
         bus.out_valid   <= rd_v2;
         bus.frame_done  <= last_v2;
         // FIFO is empty after the last odd-row read; clear realigns pointers
         bus.fifo_rd_clr <= last_v2;
         bus.fifo_wr_clr <= last_v2;
         if (rd_v2)
            bus.out_data <= vmax;
         if (pair && (state == EVEN_ROW))
            bus.fifo_wr_data <= hmax;
         if (pair && (state == ODD_ROW))
            hmax_q <= hmax;
         if (bus.in_valid) begin
            if (!col[0])
               hold_q <= bus.in_data;
            if (col_last) begin
               col   <= '0;
               state <= (state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
               row   <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule
